// File: rtl/serial_slave_pkg.sv
// Shared types and helpers for the serial burst BRAM slave.
package serial_slave_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_WDATA, S_WCOMMIT, S_RISSUE, S_RWAIT, S_RSHIFT
    } state_t;

    // Smallest width able to hold the values 0..n.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) w = w + 1;
        return w;
    endfunction

    // Even parity over a zero-extended word: returns the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple-dual-port block RAM with registered read; READ_LATENCY 1 or 2.
module bram_sdp #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int MEM_SIZE     = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        if (ren) rd_q <= mem[raddr];
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rd_q2;
            always_ff @(posedge clk) rd_q2 <= rd_q;
            assign rdata = rd_q2;
        end else begin : g_lat1
            assign rdata = rd_q;
        end
    endgenerate

endmodule

// File: rtl/serial_burst_bram_slave.sv
// Serial-bus slave with burst access to an internal BRAM and an LED mirror register.
// Define SERIAL_PARITY_EN to add an even-parity bit to every write and read beat.
module serial_burst_bram_slave
    import serial_slave_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int MEM_SIZE     = 4096,
    parameter int LEN_WIDTH    = 4,
    parameter int READ_LATENCY = 1,
    parameter int LED_ADDR     = 4095
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic                  serr,
    output logic [DATA_WIDTH-1:0] demo_data,
    output logic [DATA_WIDTH-1:0] led
);

`ifdef SERIAL_PARITY_EN
    localparam int BEAT_BITS = DATA_WIDTH + 1;
`else
    localparam int BEAT_BITS = DATA_WIDTH;
`endif
    localparam int MAX_AL = (ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH;
    localparam int MAX_B  = (MAX_AL > BEAT_BITS) ? MAX_AL : BEAT_BITS;
    localparam int CNT_W  = cnt_width(MAX_B);

    localparam logic [CNT_W-1:0]      ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]      LEN_LAST  = CNT_W'(LEN_WIDTH - 1);
    localparam logic [CNT_W-1:0]      BEAT_LAST = CNT_W'(BEAT_BITS - 1);
    localparam logic [CNT_W-1:0]      WAIT_LAST = CNT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0]   MEM_LIM   = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] MEM_TOP   = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] LED_A     = ADDR_WIDTH'(LED_ADDR);

    state_t                  state, nstate;
    logic                    mode;
    logic [ADDR_WIDTH-1:0]   addr, next_addr;
    logic [LEN_WIDTH-1:0]    len, beat;
    logic [CNT_W-1:0]        cnt;
    logic [BEAT_BITS-1:0]    wsh, rsh, rword;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    in_range, par_ok, wen, ren, adv;

    assign in_range  = {1'b0, addr} < MEM_LIM;
    // Only the last implemented word wraps; out-of-range addresses just roll over the field.
    assign next_addr = (addr == MEM_TOP) ? '0 : addr + ADDR_WIDTH'(1);
    assign srdata    = rsh[0];

`ifdef SERIAL_PARITY_EN
    assign par_ok = (wsh[DATA_WIDTH] == even_parity(64'(wsh[DATA_WIDTH-1:0])));
    assign rword  = in_range ? {even_parity(64'(rdata)), rdata} : '0;
`else
    assign par_ok = 1'b1;
    assign rword  = in_range ? rdata : '0;
`endif

    bram_sdp #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .MEM_SIZE(MEM_SIZE), .READ_LATENCY(READ_LATENCY)
    ) u_bram (
        .clk(clk), .wen(wen), .waddr(addr), .wdata(wsh[DATA_WIDTH-1:0]),
        .ren(ren), .raddr(addr), .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (rstn) state <= S_IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate = state;
        sready = 1'b0;
        wen    = 1'b0;
        ren    = 1'b0;
        adv    = 1'b0;
        unique case (state)
            S_IDLE: begin
                sready = 1'b1;
                if (mvalid) nstate = S_ADDR;
            end
            S_ADDR: begin
                adv = mvalid;
                if (mvalid && cnt == ADDR_LAST) nstate = S_LEN;
            end
            S_LEN: begin
                adv = mvalid;
                if (mvalid && cnt == LEN_LAST) nstate = mode ? S_WDATA : S_RISSUE;
            end
            S_WDATA: begin
                adv = mvalid;
                if (mvalid && cnt == BEAT_LAST) nstate = S_WCOMMIT;
            end
            S_WCOMMIT: begin
                wen    = in_range && par_ok;
                nstate = (beat == len) ? S_IDLE : S_WDATA;
            end
            S_RISSUE: begin
                ren    = 1'b1;
                nstate = S_RWAIT;
            end
            S_RWAIT: begin
                adv = 1'b1;
                if (cnt == WAIT_LAST) nstate = S_RSHIFT;
            end
            S_RSHIFT: begin
                adv = 1'b1;
                if (cnt == BEAT_LAST) nstate = (beat == len) ? S_IDLE : S_RISSUE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            mode      <= 1'b0;
            addr      <= '0;
            len       <= '0;
            beat      <= '0;
            cnt       <= '0;
            wsh       <= '0;
            rsh       <= '0;
            svalid    <= 1'b0;
            serr      <= 1'b0;
            demo_data <= '0;
            led       <= '0;
        end else begin
            serr <= 1'b0;
            // Bit 0 of the address is taken in IDLE, so ADDR counts from 1.
            if (state != nstate) cnt <= (state == S_IDLE) ? CNT_W'(1) : '0;
            else if (adv)        cnt <= cnt + CNT_W'(1);

            unique case (state)
                S_IDLE: if (mvalid) begin
                    mode <= smode;
                    beat <= '0;
                    addr <= ADDR_WIDTH'({swdata, addr} >> 1);
                end
                S_ADDR:  if (mvalid) addr <= ADDR_WIDTH'({swdata, addr} >> 1);
                S_LEN:   if (mvalid) len  <= LEN_WIDTH'({swdata, len} >> 1);
                S_WDATA: if (mvalid) wsh  <= BEAT_BITS'({swdata, wsh} >> 1);
                S_WCOMMIT: begin
                    if (wen) begin
                        demo_data <= wsh[DATA_WIDTH-1:0];
                        if (addr == LED_A) led <= wsh[DATA_WIDTH-1:0];
                    end else begin
                        serr <= 1'b1;
                    end
                    addr <= next_addr;
                    beat <= beat + LEN_WIDTH'(1);
                end
                S_RWAIT: if (cnt == WAIT_LAST) begin
                    rsh    <= rword;
                    svalid <= 1'b1;
                    serr   <= !in_range;
                end
                S_RSHIFT: begin
                    rsh <= rsh >> 1;
                    if (cnt == BEAT_LAST) begin
                        svalid <= 1'b0;
                        addr   <= next_addr;
                        beat   <= beat + LEN_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_burst_bram_slave.sv
// Directed bench: dut_a uses defaults, dut_b uses MEM_SIZE=3000; sel steers the master bus.
module tb_serial_burst_bram_slave;
    localparam int DW = 8, AW = 12, LW = 4;
`ifdef SERIAL_PARITY_EN
    localparam int RB = DW + 1;
`else
    localparam int RB = DW;
`endif

    logic clk = 1'b0;
    logic rstn, swdata, smode, mvalid, sel;
    logic a_srdata, a_svalid, a_sready, a_serr, b_srdata, b_svalid, b_sready, b_serr;
    logic [DW-1:0] a_demo, a_led, b_demo, b_led;
    logic srdata, svalid, sready, serr;
    logic [DW-1:0] demo_data, led;

    serial_burst_bram_slave dut_a (
        .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid & ~sel),
        .srdata(a_srdata), .svalid(a_svalid), .sready(a_sready), .serr(a_serr),
        .demo_data(a_demo), .led(a_led)
    );
    serial_burst_bram_slave #(.MEM_SIZE(3000)) dut_b (
        .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid & sel),
        .srdata(b_srdata), .svalid(b_svalid), .sready(b_sready), .serr(b_serr),
        .demo_data(b_demo), .led(b_led)
    );

    assign srdata    = sel ? b_srdata : a_srdata;
    assign svalid    = sel ? b_svalid : a_svalid;
    assign sready    = sel ? b_sready : a_sready;
    assign serr      = sel ? b_serr   : a_serr;
    assign demo_data = sel ? b_demo   : a_demo;
    assign led       = sel ? b_led    : a_led;

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int serr_cnt = 0, serr_base;
    int gbit, rdy_err;
    int stall_pos[$];
    logic [DW-1:0] rd_w[4];
    logic rd_p[4];
    int rd_n, first_lat, sv_cycles;
    int beat_start[4];

    always @(negedge clk) if (serr) serr_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        if (stall_pos.size() > 0 && stall_pos[0] == gbit) begin
            void'(stall_pos.pop_front());
            @(negedge clk);
            mvalid = 1'b0; swdata = ~b;
            if (sready) rdy_err++;
        end
        @(negedge clk);
        if (gbit > 0 && sready) rdy_err++;
        swdata = b; mvalid = 1'b1;
        gbit++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); mvalid = 1'b0; end
    endtask

    task automatic write_cmd(input logic [AW-1:0] a, input logic [LW-1:0] len,
                             input logic [DW-1:0] d[4], input bit bad_par);
        gbit = 0; rdy_err = 0; smode = 1'b1;
        for (int i = 0; i < AW; i++) send_bit(a[i]);
        for (int i = 0; i < LW; i++) send_bit(len[i]);
        for (int b = 0; b <= int'(len); b++) begin
            for (int i = 0; i < DW; i++) send_bit(d[b][i]);
`ifdef SERIAL_PARITY_EN
            send_bit((^d[b]) ^ bad_par);
`endif
            @(negedge clk);
            mvalid = 1'b0;
            if (sready) rdy_err++;
        end
        @(negedge clk);
        chk("wr_sready_after_commit", sready, 1);
        chk("wr_sready_busy", rdy_err, 0);
        idle(1);
    endtask

    task automatic read_cmd(input logic [AW-1:0] a, input logic [LW-1:0] len, input int abort_at);
        int cyc, bi;
        gbit = 0; smode = 1'b0; rd_n = 0; sv_cycles = 0; first_lat = -1; bi = 0;
        for (int i = 0; i < 4; i++) begin rd_w[i] = '0; rd_p[i] = 1'b0; beat_start[i] = 0; end
        for (int i = 0; i < AW; i++) send_bit(a[i]);
        for (int i = 0; i < LW; i++) send_bit(len[i]);
        for (cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk);
            mvalid = 1'b0;
            if (svalid) begin
                sv_cycles++;
                if (bi == 0) begin
                    if (first_lat < 0) first_lat = cyc;
                    if (rd_n < 4) beat_start[rd_n] = cyc;
                end
                if (rd_n < 4) begin
                    if (bi < DW) rd_w[rd_n][bi] = srdata;
                    else         rd_p[rd_n] = srdata;
                end
                bi++;
                if (bi == RB) begin bi = 0; rd_n++; end
                if (sv_cycles == abort_at) begin
                    rstn = 1'b1;
                    @(negedge clk);
                    rstn = 1'b0;
                    return;
                end
            end else if (sready && rd_n == int'(len) + 1) begin
                break;
            end
        end
        chk("rd_within_budget", cyc < 400, 1);
    endtask

    initial begin
        rstn = 1'b1; swdata = 1'b0; smode = 1'b0; mvalid = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_srdata", srdata, 0);
        chk("rst_svalid", svalid, 0);
        chk("rst_sready", sready, 1);
        chk("rst_serr", serr, 0);
        chk("rst_demo", demo_data, 0);
        chk("rst_led", led, 0);
        rstn = 1'b0;
        idle(2);

        // 1: single write then read
        serr_base = serr_cnt;
        write_cmd(12'h010, 4'd0, '{8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
        chk("t1_demo", demo_data, 8'hA5);
        read_cmd(12'h010, 4'd0, 0);
        chk("t1_rdata", rd_w[0], 8'hA5);
        chk("t1_latency", first_lat, 3);
        chk("t1_svalid_cycles", sv_cycles, RB);
        chk("t1_serr", serr_cnt - serr_base, 0);

        // 2: burst write across the top of memory, wrap, LED mirror
        write_cmd(12'hFFE, 4'd3, '{8'h01, 8'h02, 8'h03, 8'h04}, 1'b0);
        chk("t2_led", led, 8'h02);
        chk("t2_demo", demo_data, 8'h04);
        read_cmd(12'hFFE, 4'd3, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_rd%0d", i), rd_w[i], 32'(i + 1));
        chk("t2_beat_gap", beat_start[1] - beat_start[0], RB + 2);
        read_cmd(12'h000, 4'd1, 0);
        chk("t2_wrap0", rd_w[0], 8'h03);
        chk("t2_wrap1", rd_w[1], 8'h04);
        chk("t2_serr", serr_cnt - serr_base, 0);

        // 3: MEM_SIZE=3000 boundary
        sel = 1'b1;
        idle(1);
        write_cmd(12'd0, 4'd0, '{8'h33, 8'h00, 8'h00, 8'h00}, 1'b0);
        write_cmd(12'd2999, 4'd0, '{8'h77, 8'h00, 8'h00, 8'h00}, 1'b0);
        serr_base = serr_cnt;
        write_cmd(12'd3000, 4'd0, '{8'h99, 8'h00, 8'h00, 8'h00}, 1'b0);
        chk("t3_wr_serr", serr_cnt - serr_base, 1);
        chk("t3_demo_kept", demo_data, 8'h77);
        read_cmd(12'd2999, 4'd0, 0);
        chk("t3_rd2999", rd_w[0], 8'h77);
        read_cmd(12'd0, 4'd0, 0);
        chk("t3_rd0", rd_w[0], 8'h33);
        serr_base = serr_cnt;
        read_cmd(12'd3000, 4'd0, 0);
        idle(1);
        chk("t3_rd3000", rd_w[0], 8'h00);
        chk("t3_rd_serr", serr_cnt - serr_base, 1);
        sel = 1'b0;
        idle(1);

        // 4: stalls inside ADDR, LEN and WDATA give the same result
        write_cmd(12'h050, 4'd1, '{8'hC3, 8'h3C, 8'h00, 8'h00}, 1'b0);
        stall_pos = '{3, 7, 13, 18, 22};
        write_cmd(12'h060, 4'd1, '{8'hC3, 8'h3C, 8'h00, 8'h00}, 1'b0);
        chk("t4_stalls_used", stall_pos.size(), 0);
        read_cmd(12'h050, 4'd1, 0);
        chk("t4_ref0", rd_w[0], 8'hC3);
        chk("t4_ref1", rd_w[1], 8'h3C);
        read_cmd(12'h060, 4'd1, 0);
        chk("t4_stall0", rd_w[0], 8'hC3);
        chk("t4_stall1", rd_w[1], 8'h3C);

        // 5: reset in the 4th svalid cycle of a read burst
        read_cmd(12'h050, 4'd3, 4);
        chk("t5_svalid_after_rst", svalid, 0);
        chk("t5_sready_after_rst", sready, 1);
        chk("t5_demo_after_rst", demo_data, 0);
        idle(1);
        write_cmd(12'h020, 4'd0, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1'b0);
        read_cmd(12'h020, 4'd0, 0);
        chk("t5_rd", rd_w[0], 8'h5A);
        chk("t5_demo", demo_data, 8'h5A);

`ifdef SERIAL_PARITY_EN
        // 6: parity error drops the write; reads carry a parity bit
        write_cmd(12'h030, 4'd0, '{8'h11, 8'h00, 8'h00, 8'h00}, 1'b0);
        serr_base = serr_cnt;
        write_cmd(12'h030, 4'd0, '{8'h0F, 8'h00, 8'h00, 8'h00}, 1'b1);
        chk("t6_par_serr", serr_cnt - serr_base, 1);
        chk("t6_demo_kept", demo_data, 8'h11);
        read_cmd(12'h030, 4'd0, 0);
        chk("t6_rd_kept", rd_w[0], 8'h11);
        write_cmd(12'h031, 4'd0, '{8'h0F, 8'h00, 8'h00, 8'h00}, 1'b0);
        read_cmd(12'h031, 4'd0, 0);
        chk("t6_rd", rd_w[0], 8'h0F);
        chk("t6_rd_par", rd_p[0], 0);
        chk("t6_svalid_cycles", sv_cycles, 9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
